// File: rtl/nfcv2_page_buffer_reader_pkg.sv
// Shared types and constants for the NFC v2 page-buffer reader.
package nfcv2_page_buffer_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int unsigned FIFO_DEPTH = 3;
    localparam int unsigned FIFO_CNT_W = 2;
    localparam int unsigned FIFO_PTR_W = 2;

    // Circular pointer advance over a non-power-of-two depth.
    function automatic logic [FIFO_PTR_W-1:0] fifo_ptr_inc(input logic [FIFO_PTR_W-1:0] ptr);
        if (ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return ptr + FIFO_PTR_W'(1);
    endfunction

endpackage

// File: rtl/nfcv2_pbr_out_fifo.sv
// Three-entry output FIFO holding {last, data} words captured from the page buffer.
module nfcv2_pbr_out_fifo
    import nfcv2_page_buffer_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]      mem_d [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full FIFO is only taken when a pop frees the slot that same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && ((cnt_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);

        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = fifo_ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = fifo_ptr_inc(rd_ptr_q);
        end

        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + FIFO_CNT_W'(1);
            2'b01:   cnt_d = cnt_q - FIFO_CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = cnt_q;

endmodule

// File: rtl/nfcv2_page_buffer_reader.sv
// Streams cmd_len words from a page-buffer read port, starting at cmd_addr, into a valid/ready sink.
module nfcv2_page_buffer_reader
    import nfcv2_page_buffer_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int unsigned OCC_W   = FIFO_CNT_W + 1;
    localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    logic                  fifo_valid;
    logic [ENTRY_W-1:0]    fifo_data;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0]      occupancy;
    logic                  issue_ok;
    logic                  last_issue;
    logic                  pop;

    // Flow control uses only registered occupancy and in-flight state, so m_ready never reaches enb.
    assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight_q);
    assign issue_ok   = (state_q == ISSUE) && (occupancy < OCC_W'(FIFO_DEPTH));
    assign last_issue = (issued_q == len_q - LEN_WIDTH'(1));
    assign pop        = fifo_valid && m_ready;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        len_d           = len_q;
        issued_d        = issued_q;
        inflight_d      = 1'b0;
        inflight_last_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid && (cmd_len != '0)) begin
                    addr_d   = cmd_addr;
                    len_d    = cmd_len;
                    issued_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ok) begin
                    inflight_d      = 1'b1;
                    inflight_last_d = last_issue;
                    addr_d          = addr_q + ADDR_WIDTH'(1);
                    issued_d        = issued_q + LEN_WIDTH'(1);
                    if (last_issue) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // Read data returns one cycle after enb; the in-flight flag marks that capture cycle.
    nfcv2_pbr_out_fifo #(
        .WIDTH (ENTRY_W)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, doutb}),
        .pop       (pop),
        .out_valid (fifo_valid),
        .out_data  (fifo_data),
        .count     (fifo_count)
    );

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign enb       = issue_ok;
    assign addrb     = addr_q;
    assign m_valid   = fifo_valid;
    assign m_data    = fifo_data[DATA_WIDTH-1:0];
    assign m_last    = fifo_data[DATA_WIDTH] & fifo_valid;

endmodule

// File: tb/tb_nfcv2_page_buffer_reader.sv
// Directed bench for nfcv2_page_buffer_reader: command table plus reset and empty-command sequences.
module tb_nfcv2_page_buffer_reader;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;

    int    checks = 0;
    int    errors = 0;
    string tag    = "init";

    // mode: 0 = m_ready always 1, 1 = random 50%, 2 = held low until 10 cycles after first m_valid
    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        int            mode;
        logic [AW-1:0] exp_first;
        logic [AW-1:0] exp_last;
        int            exp_done;
    } vec_t;

    vec_t vecs [6];

    nfcv2_page_buffer_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {8'hA5, 3'b000, a, ~a[7:0]};
    endfunction

    // Page-buffer model with one cycle of read latency.
    always @(posedge clk) begin
        if (enb) doutb <= mem_word(addrb);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h required %0h", tag, name, got, exp);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int            n_enb = 0, n_xfer = 0, n_last = 0;
        int            first_c = -1, last_c = -1;
        int            addr_errs = 0, data_errs = 0, last_errs = 0, stab_errs = 0;
        int            stall_enb = 0, max_out = 0, outstanding;
        int            budget;
        logic [AW-1:0] first_seen = '0, last_seen = '0, exp_a;
        logic          prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
        logic [DW-1:0] prev_d = '0;
        bit            done = 1'b0;

        budget = int'(v.len) * 4 + 40;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        m_ready   = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        check("accept_ready", 64'(cmd_ready), 64'd1);

        for (int c = 1; c <= budget && !done; c++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            case (v.mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (first_c >= 0) && (c >= first_c + 10);
            endcase
            @(negedge clk);
            if (c == 1) begin
                check("busy_in_issue", 64'(busy), 64'd1);
                check("ready_low_in_issue", 64'(cmd_ready), 64'd0);
            end
            if (n_xfer == int'(v.len)) begin
                check("idle_after_last", 64'({cmd_ready, busy, m_valid}), 64'b100);
                done = 1'b1;
            end else begin
                outstanding = n_enb - n_xfer + int'(enb);
                if (outstanding > max_out) max_out = outstanding;
                if (enb) begin
                    exp_a = AW'(int'(v.addr) + n_enb);
                    if (addrb !== exp_a) addr_errs++;
                    if (n_enb == 0) first_seen = addrb;
                    last_seen = addrb;
                    if (!m_ready) stall_enb++;
                    n_enb++;
                end
                if (prev_v && !prev_r && (!m_valid || m_data !== prev_d || m_last !== prev_l))
                    stab_errs++;
                if (m_valid && first_c < 0) first_c = c;
                if (m_valid && m_ready) begin
                    if (m_data !== mem_word(AW'(int'(v.addr) + n_xfer))) data_errs++;
                    if (m_last !== (n_xfer == int'(v.len) - 1)) last_errs++;
                    if (m_last) n_last++;
                    n_xfer++;
                    last_c = c;
                end
                prev_v = m_valid;
                prev_r = m_ready;
                prev_d = m_data;
                prev_l = m_last;
            end
        end

        check("completed_in_budget", 64'(done), 64'd1);
        check("first_valid_latency", 64'(first_c), 64'd3);
        check("enb_pulses", 64'(n_enb), 64'(v.len));
        check("words_out", 64'(n_xfer), 64'(v.len));
        check("single_m_last", 64'(n_last), 64'd1);
        check("addr_seq_errs", 64'(addr_errs), 64'd0);
        check("data_errs", 64'(data_errs), 64'd0);
        check("last_flag_errs", 64'(last_errs), 64'd0);
        check("stall_stability_errs", 64'(stab_errs), 64'd0);
        check("first_addrb", 64'(first_seen), 64'(v.exp_first));
        check("last_addrb", 64'(last_seen), 64'(v.exp_last));
        check("outstanding_le3", 64'(max_out <= 3), 64'd1);
        if (v.exp_done >= 0) check("last_xfer_cycle", 64'(last_c), 64'(v.exp_done));
        if (v.mode == 2) check("enb_during_stall_le3", 64'(stall_enb <= 3), 64'd1);
    endtask

    initial begin
        int   seen;
        logic bad;
        vec_t v2;

        vecs[0] = '{13'h0010, 14'd4,    0, 13'h0010, 13'h0013, 6};
        vecs[1] = '{13'h1FFE, 14'd4,    0, 13'h1FFE, 13'h0001, 6};
        vecs[2] = '{13'h0200, 14'd8,    2, 13'h0200, 13'h0207, -1};
        vecs[3] = '{13'h0000, 14'd1,    0, 13'h0000, 13'h0000, 3};
        vecs[4] = '{13'h0005, 14'd3,    0, 13'h0005, 13'h0007, 5};
        vecs[5] = '{13'h1000, 14'd8192, 1, 13'h1000, 13'h0FFF, -1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tag = "reset";
        check("outputs", 64'({enb, m_valid, m_last, busy, cmd_ready}), 64'b00001);
        check("addrb", 64'(addrb), 64'd0);
        check("m_data", 64'(m_data), 64'd0);

        for (int i = 0; i < 6; i++) begin
            tag = $sformatf("vec%0d", i);
            run_cmd(vecs[i]);
        end

        tag = "len0";
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 13'h0055;
        cmd_len   = '0;
        m_ready   = 1'b1;
        @(negedge clk);
        check("accept_ready", 64'(cmd_ready), 64'd1);
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1 cmd_valid = 1'b0;
            @(negedge clk);
            if (enb || m_valid || !cmd_ready || busy) bad = 1'b1;
        end
        check("quiet", 64'(bad), 64'd0);

        tag = "mid_reset";
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 13'h0400;
        cmd_len   = 14'd16;
        m_ready   = 1'b1;
        seen      = 0;
        for (int c = 0; c < 20 && seen < 3; c++) begin
            @(negedge clk);
            if (m_valid && m_ready) seen++;
            @(posedge clk); #1 cmd_valid = 1'b0;
        end
        check("three_words_seen", 64'(seen), 64'd3);
        #1 rst = 1'b1;
        #1;
        check("outputs", 64'({enb, m_valid, m_last, busy, cmd_ready}), 64'b00001);
        check("addrb", 64'(addrb), 64'd0);
        check("m_data", 64'(m_data), 64'd0);
        #1 rst = 1'b0;

        tag = "after_reset";
        v2 = '{13'h0100, 14'd2, 0, 13'h0100, 13'h0101, 4};
        run_cmd(v2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
